// File: rtl/jtag_axi_arbiter.sv
// jtag_axi_arbiter
// Shares one single-beat 64-bit AXI master port between NUM_REQ simple
// requesters (e.g. the JTAG debug path and a boot loader). It arbitrates
// round-robin with one transaction in flight and drives the AR/R or AW/W/B
// channels itself. Each requester gets a one-cycle completion pulse that
// carries the load data and an error flag.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i/we_i           per-requester request (held until granted) and store flag
//   addr_i/wdata_i       packed per-requester byte address and store data
//   gnt_o                one-hot grant pulse, combinational in IDLE
//   rvalid_o             one-hot completion pulse; rdata_o/err_o valid with it
//   ar_*/r_*             AXI read address / read data channels
//   aw_*/w_*/b_*         AXI write address / write data / write response channels

module jtag_axi_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          err_o,
  output logic                          ar_valid_o,
  input  logic                          ar_ready_i,
  output logic [ADDR_WIDTH-1:0]         ar_addr_o,
  output logic [ID_WIDTH-1:0]           ar_id_o,
  input  logic                          r_valid_i,
  output logic                          r_ready_o,
  input  logic [DATA_WIDTH-1:0]         r_data_i,
  input  logic [1:0]                    r_resp_i,
  input  logic                          r_last_i,
  output logic                          aw_valid_o,
  input  logic                          aw_ready_i,
  output logic [ADDR_WIDTH-1:0]         aw_addr_o,
  output logic [ID_WIDTH-1:0]           aw_id_o,
  output logic                          w_valid_o,
  input  logic                          w_ready_i,
  output logic [DATA_WIDTH-1:0]         w_data_o,
  output logic [DATA_WIDTH/8-1:0]       w_strb_o,
  output logic                          w_last_o,
  input  logic                          b_valid_i,
  output logic                          b_ready_o,
  input  logic [1:0]                    b_resp_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    err_sticky_q;
  logic                    aw_done_q;
  logic                    w_done_q;

  logic                    arb_found_s;
  logic [IDX_W-1:0]        arb_idx_s;
  logic [IDX_W-1:0]        ptr_next_s;
  logic [ADDR_WIDTH-1:0]   addr_sel_s;
  logic [DATA_WIDTH-1:0]   wdata_sel_s;
  logic                    aw_hs_s;
  logic                    w_hs_s;
  logic                    unused_s;

  // Round-robin pick: first requester at or after the pointer, wrapping.
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      arb_idx_s   = (!arb_found_s && req_i[IDX_W'((int'(ptr_q) + i) % int'(NUM_REQ))])
                    ? IDX_W'((int'(ptr_q) + i) % int'(NUM_REQ)) : arb_idx_s;
      arb_found_s = arb_found_s | req_i[IDX_W'((int'(ptr_q) + i) % int'(NUM_REQ))];
    end
  end

  assign ptr_next_s  = (arb_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx_s + IDX_W'(1);
  assign addr_sel_s  = addr_i[arb_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata_sel_s = wdata_i[arb_idx_s*DATA_WIDTH +: DATA_WIDTH];
  assign aw_hs_s     = (state_q == S_WR_REQ) && !aw_done_q && aw_ready_i;
  assign w_hs_s      = (state_q == S_WR_REQ) && !w_done_q && w_ready_i;
  // Only resp[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY; address low bits are forced to 0.
  assign unused_s    = ^{r_resp_i[0], b_resp_i[0], addr_sel_s[2:0]};

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = arb_found_s ? (we_i[arb_idx_s] ? S_WR_REQ : S_RD_ADDR) : S_IDLE;
      S_RD_ADDR: state_d = ar_ready_i ? S_RD_DATA : S_RD_ADDR;
      S_RD_DATA: state_d = (r_valid_i && r_last_i) ? S_DONE : S_RD_DATA;
      // AW and W may complete in either order or together.
      S_WR_REQ:  state_d = ((aw_done_q || aw_ready_i) && (w_done_q || w_ready_i)) ? S_WR_RESP : S_WR_REQ;
      S_WR_RESP: state_d = b_valid_i ? S_DONE : S_WR_RESP;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Command latch, round-robin pointer, response capture and write-channel flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q        <= '0;
      idx_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arb_found_s) begin
            idx_q   <= arb_idx_s;
            we_q    <= we_i[arb_idx_s];
            addr_q  <= {addr_sel_s[ADDR_WIDTH-1:3], 3'b000};
            wdata_q <= wdata_sel_s;
            ptr_q   <= ptr_next_s;
          end else begin
            ptr_q   <= ptr_q;
          end
        end
        S_RD_DATA: begin
          if (r_valid_i) begin
            err_sticky_q <= err_sticky_q | r_resp_i[1];
            // Only the last beat's data is presented; the error covers every beat.
            if (r_last_i) begin
              rdata_q <= r_data_i;
              err_q   <= err_sticky_q | r_resp_i[1];
            end else begin
              rdata_q <= rdata_q;
            end
          end else begin
            err_sticky_q <= err_sticky_q;
          end
        end
        S_WR_REQ: begin
          aw_done_q <= aw_done_q | aw_hs_s;
          w_done_q  <= w_done_q | w_hs_s;
        end
        S_WR_RESP: begin
          if (b_valid_i) begin
            rdata_q <= '0;
            err_q   <= b_resp_i[1];
          end else begin
            err_q   <= err_q;
          end
        end
        S_DONE: begin
          err_sticky_q <= 1'b0;
          aw_done_q    <= 1'b0;
          w_done_q     <= 1'b0;
        end
        default: begin
          err_sticky_q <= err_sticky_q;
        end
      endcase
    end
  end

  // Output decode from state and latched command.
  always_comb begin
    gnt_o      = '0;
    rvalid_o   = '0;
    ar_valid_o = 1'b0;
    r_ready_o  = 1'b0;
    aw_valid_o = 1'b0;
    w_valid_o  = 1'b0;
    b_ready_o  = 1'b0;
    case (state_q)
      // Reset is folded in so no grant escapes while held in reset.
      S_IDLE:    gnt_o      = (arb_found_s && rst_ni) ? (NUM_REQ'(1'b1) << arb_idx_s) : '0;
      S_RD_ADDR: ar_valid_o = 1'b1;
      S_RD_DATA: r_ready_o  = 1'b1;
      S_WR_REQ: begin
        aw_valid_o = !aw_done_q;
        w_valid_o  = !w_done_q;
      end
      S_WR_RESP: b_ready_o  = 1'b1;
      S_DONE:    rvalid_o   = NUM_REQ'(1'b1) << idx_q;
      default:   gnt_o      = '0;
    endcase
    ar_addr_o = ar_valid_o ? addr_q : '0;
    ar_id_o   = ar_valid_o ? ID_WIDTH'(idx_q) : '0;
    aw_addr_o = aw_valid_o ? addr_q : '0;
    aw_id_o   = aw_valid_o ? ID_WIDTH'(idx_q) : '0;
    w_data_o  = w_valid_o ? wdata_q : '0;
    w_strb_o  = {(DATA_WIDTH/8){w_valid_o}};
    w_last_o  = w_valid_o;
    rdata_o   = rdata_q;
    err_o     = err_q;
  end

`ifndef SYNTHESIS
  jtag_axi_arbiter_chk u_chk (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .r_valid_i (r_valid_i),
    .r_ready_i (r_ready_o),
    .b_valid_i (b_valid_i),
    .b_ready_i (b_ready_o)
  );
`endif

endmodule

// jtag_axi_arbiter_chk
// Flags response beats offered while the arbiter is not expecting them.
module jtag_axi_arbiter_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic r_valid_i,
  input logic r_ready_i,
  input logic b_valid_i,
  input logic b_ready_i
);
  // Read data only arrives while a read is waiting for it.
  a_no_stray_r: assert property (@(posedge clk_i) disable iff (!rst_ni) r_valid_i |-> r_ready_i);
  // Write response only arrives while a write is waiting for it.
  a_no_stray_b: assert property (@(posedge clk_i) disable iff (!rst_ni) b_valid_i |-> b_ready_i);
endmodule

// File: tb/tb_jtag_axi_arbiter.sv
module tb_jtag_axi_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            err_o;
  logic            ar_valid_o, ar_ready, r_valid, r_ready_o, r_last;
  logic [AW-1:0]   ar_addr_o, aw_addr_o;
  logic [IW-1:0]   ar_id_o, aw_id_o;
  logic [DW-1:0]   r_data, w_data_o;
  logic [1:0]      r_resp, b_resp;
  logic            aw_valid_o, aw_ready, w_valid_o, w_ready, w_last_o, b_valid, b_ready_o;
  logic [7:0]      w_strb_o;

  int checks = 0;
  int failures = 0;

  jtag_axi_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr_o), .ar_id_o(ar_id_o),
    .r_valid_i(r_valid), .r_ready_o(r_ready_o), .r_data_i(r_data), .r_resp_i(r_resp), .r_last_i(r_last),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr_o), .aw_id_o(aw_id_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready), .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid), .b_ready_o(b_ready_o), .b_resp_i(b_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) begin
        v[(p + i) % N] = 1'b1;
        return v;
      end
    end
    return v;
  endfunction

  // ---------------- transaction-level reference model ----------------
  bit          m_busy, m_we, m_ar_acc, m_aw_acc, m_w_acc, m_resp, m_err, m_last_err;
  int          m_k, m_ptr;
  logic [31:0] m_addr;
  logic [63:0] m_wdata, m_data, m_last_rdata;

  always @(negedge clk) begin
    logic [N-1:0] e_gnt, e_rv;
    bit e_arv, e_rr, e_awv, e_wv, e_br;
    if (!rst_n) begin
      chk("rst_gnt", gnt_o, 0);         chk("rst_rvalid", rvalid_o, 0);
      chk("rst_rdata", rdata_o, 0);     chk("rst_err", err_o, 0);
      chk("rst_arvalid", ar_valid_o, 0); chk("rst_rready", r_ready_o, 0);
      chk("rst_awvalid", aw_valid_o, 0); chk("rst_wvalid", w_valid_o, 0);
      chk("rst_bready", b_ready_o, 0);
      m_busy = 0; m_ptr = 0; m_resp = 0; m_last_rdata = '0; m_last_err = 0;
    end else begin
      e_gnt = '0; e_rv = '0; e_arv = 0; e_rr = 0; e_awv = 0; e_wv = 0; e_br = 0;
      if (!m_busy) e_gnt = rr_pick(req, m_ptr);
      else if (m_resp) e_rv[m_k] = 1'b1;
      else if (!m_we) begin e_arv = !m_ar_acc; e_rr = m_ar_acc; end
      else begin e_awv = !m_aw_acc; e_wv = !m_w_acc; e_br = m_aw_acc && m_w_acc; end
      chk("m_gnt", gnt_o, e_gnt);       chk("m_rvalid", rvalid_o, e_rv);
      chk("m_rdata", rdata_o, m_resp ? m_data : m_last_rdata);
      chk("m_err", err_o, m_resp ? m_err : m_last_err);
      chk("m_arvalid", ar_valid_o, e_arv); chk("m_rready", r_ready_o, e_rr);
      chk("m_awvalid", aw_valid_o, e_awv); chk("m_wvalid", w_valid_o, e_wv);
      chk("m_bready", b_ready_o, e_br);
      if (e_arv) begin chk("m_araddr", ar_addr_o, m_addr); chk("m_arid", ar_id_o, m_k); end
      if (e_awv) begin chk("m_awaddr", aw_addr_o, m_addr); chk("m_awid", aw_id_o, m_k); end
      if (e_wv) begin
        chk("m_wdata", w_data_o, m_wdata); chk("m_wstrb", w_strb_o, 8'hFF); chk("m_wlast", w_last_o, 1);
      end
      // advance the model to the next cycle
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          if (e_gnt[i]) begin
            m_busy = 1; m_k = i; m_we = we[i]; m_addr = addr[i*AW +: AW] & 32'hFFFF_FFF8;
            m_wdata = wdata[i*DW +: DW]; m_ptr = (i + 1) % N;
            m_ar_acc = 0; m_aw_acc = 0; m_w_acc = 0; m_resp = 0; m_err = 0; m_data = '0;
          end
        end
      end else if (m_resp) begin
        m_busy = 0; m_resp = 0; m_last_rdata = m_data; m_last_err = m_err;
      end else if (!m_we) begin
        if (!m_ar_acc) m_ar_acc = ar_ready;
        else if (r_valid) begin
          m_data = r_data; m_err = m_err | r_resp[1]; m_resp = r_last;
        end
      end else if (m_aw_acc && m_w_acc) begin
        if (b_valid) begin m_data = '0; m_err = b_resp[1]; m_resp = 1; end
      end else begin
        if (aw_ready) m_aw_acc = 1;
        if (w_ready)  m_w_acc = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic grant(input int k, input bit st, input logic [31:0] a, input logic [63:0] d);
    logic [N-1:0] exp_g;
    exp_g = '0; exp_g[k] = 1'b1;
    req[k] = 1'b1; we[k] = st; addr[k*AW +: AW] = a; wdata[k*DW +: DW] = d;
    #1 chk("gnt_pulse", gnt_o, exp_g);
    tick();
    req[k] = 1'b0;
  endtask

  task automatic serve_read(input int ar_dly, input logic [63:0] d, input logic [1:0] rs,
                            input bit extra, input logic [1:0] extra_rs);
    for (int i = 0; i < 20 && !ar_valid_o; i++) tick();
    chk("wait_arvalid", ar_valid_o, 1);
    repeat (ar_dly) tick();
    ar_ready = 1; tick(); ar_ready = 0;
    if (extra) begin
      r_valid = 1; r_last = 0; r_data = ~d; r_resp = extra_rs; tick();
    end
    r_valid = 1; r_last = 1; r_data = d; r_resp = rs; tick();
    r_valid = 0; r_last = 0; r_resp = 2'b00;
  endtask

  task automatic serve_write(input int wd, input int ad, input logic [1:0] bs);
    int mx;
    mx = (wd > ad) ? wd : ad;
    for (int i = 0; i < 20 && !aw_valid_o; i++) tick();
    chk("wait_awvalid", aw_valid_o, 1);
    for (int c = 0; c <= mx; c++) begin
      w_ready = (c == wd); aw_ready = (c == ad); tick();
      if (c == wd && c < ad) begin
        chk("aw_hold", aw_valid_o, 1); chk("w_dropped", w_valid_o, 0);
      end
    end
    w_ready = 0; aw_ready = 0;
    chk("wr_resp_state", b_ready_o, 1);
    b_valid = 1; b_resp = bs; tick();
    b_valid = 0; b_resp = 2'b00;
  endtask

  initial begin
    int exp_order [4] = '{0, 1, 0, 1};
    int prev;
    rst_n = 0; req = '0; we = '0; addr = '0; wdata = '0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = 2'b00; r_last = 0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 2'b00;
    #1 chk("reset_rdata", rdata_o, 0);
    chk("reset_arvalid", ar_valid_o, 0);
    tick(); tick();
    rst_n = 1;

    // single load from requester 0, unaligned address
    grant(0, 0, 32'h1C00_0013, 64'h0);
    chk("load_araddr", ar_addr_o, 32'h1C00_0010);
    chk("load_arid", ar_id_o, 0);
    serve_read(1, 64'hDEAD_BEEF_0123_4567, 2'b00, 0, 2'b00);
    chk("load_rvalid", rvalid_o, 2'b01);
    chk("load_rdata", rdata_o, 64'hDEAD_BEEF_0123_4567);
    chk("load_err", err_o, 0);
    tick();

    // single store from requester 1, W accepted two cycles before AW
    grant(1, 1, 32'h1000_0008, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("store_awaddr", aw_addr_o, 32'h1000_0008);
    chk("store_wstrb", w_strb_o, 8'hFF);
    serve_write(0, 2, 2'b00);
    chk("store_rvalid", rvalid_o, 2'b10);
    chk("store_rdata", rdata_o, 0);
    tick();

    // round robin with both requesters holding req
    req = 2'b11; we = 2'b00;
    addr[0 +: AW] = 32'h0000_0100; addr[AW +: AW] = 32'h0000_0200;
    prev = -1;
    for (int t = 0; t < 4; t++) begin
      int g;
      for (int i = 0; i < 10 && gnt_o == '0; i++) tick();
      g = gnt_o[1] ? 1 : 0;
      chk("rr_order", g, exp_order[t]);
      checks++;
      if (g == prev) begin
        failures++;
        $display("FAIL rr_repeat actual=%0d required=not %0d", g, prev);
      end
      prev = g;
      tick();
      serve_read(0, 64'h100 + 64'(t), 2'b00, 0, 2'b00);
      chk("rr_rvalid_idx", rvalid_o[g], 1);
      tick();
    end
    req = 2'b00;

    // error paths and sticky-error clear
    grant(0, 1, 32'h2000_0000, 64'h1111_2222_3333_4444);
    serve_write(1, 0, 2'b10);
    chk("store_err", err_o, 1);
    tick();
    grant(1, 0, 32'h3000_0004, 64'h0);
    serve_read(0, 64'h0123_4567_89AB_CDEF, 2'b00, 1, 2'b11);
    chk("sticky_err", err_o, 1);
    chk("lastbeat_data", rdata_o, 64'h0123_4567_89AB_CDEF);
    tick();
    grant(0, 0, 32'h3000_0008, 64'h0);
    serve_read(0, 64'h5555_0000_AAAA_FFFF, 2'b00, 0, 2'b00);
    chk("sticky_cleared", err_o, 0);
    tick();

    // AW and W accepted together
    grant(1, 1, 32'h4000_0010, 64'hFEDC_BA98_7654_3210);
    serve_write(0, 0, 2'b00);
    chk("simul_rvalid", rvalid_o, 2'b10);
    chk("simul_err", err_o, 0);
    tick();

    // reset while waiting for read data
    grant(0, 0, 32'h5000_0000, 64'h0);
    for (int i = 0; i < 20 && !ar_valid_o; i++) tick();
    ar_ready = 1; tick(); ar_ready = 0;
    chk("pre_rst_rready", r_ready_o, 1);
    #2 rst_n = 0;
    #1 chk("rst_async_rready", r_ready_o, 0);
    chk("rst_async_rdata", rdata_o, 0);
    chk("rst_async_rvalid", rvalid_o, 0);
    tick();
    rst_n = 1;
    grant(1, 0, 32'h6000_0020, 64'h0);
    serve_read(0, 64'h0BAD_F00D_0000_0001, 2'b00, 0, 2'b00);
    chk("post_rst_rvalid", rvalid_o, 2'b10);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtag_axi_arbiter.md
Name: jtag_axi_arbiter

Overview:
- Shares one 64-bit AXI master port between NUM_REQ simple single-word requesters, e.g. the JTAG debug access path and a boot/test loader.
- Round-robin arbitration with exactly one AXI transaction outstanding at a time.
- Sequences the AR/R and AW/W/B channels itself and returns per-requester completion pulses carrying read data and an error flag.
- Sits between the requester logic and the SoC AXI interconnect.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 64, data width; fixed 64 in this revision.
- ID_WIDTH, 4, AXI ID width; must satisfy 2**ID_WIDTH >= NUM_REQ.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  NUM_REQ  request per requester; held until granted
- we_i  in  NUM_REQ  1 = store, 0 = load
- addr_i  in  NUM_REQ*ADDR_WIDTH  packed byte addresses
- wdata_i  in  NUM_REQ*DATA_WIDTH  packed store data
- gnt_o  out  NUM_REQ  one-hot, one-cycle grant pulse
- rvalid_o  out  NUM_REQ  one-hot, one-cycle completion pulse
- rdata_o  out  DATA_WIDTH  load data, valid with rvalid_o
- err_o  out  1  error, valid with rvalid_o
- ar_valid_o / ar_ready_i / ar_addr_o[ADDR_WIDTH] / ar_id_o[ID_WIDTH]  read address channel
- r_valid_i / r_ready_o / r_data_i[64] / r_resp_i[2] / r_last_i  read data channel
- aw_valid_o / aw_ready_i / aw_addr_o[ADDR_WIDTH] / aw_id_o[ID_WIDTH]  write address channel
- w_valid_o / w_ready_i / w_data_o[64] / w_strb_o[8] / w_last_o  write data channel
- b_valid_i / b_ready_o / b_resp_i[2]  write response channel
- The integrator ties size=3'b011, len=0, burst=INCR, and cache/prot/lock/qos/region/user=0.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = 0 (requester 0 highest priority); latched command registers 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE, arbitration:
  - When any req_i is set, select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Pulse gnt_o[k] combinationally in that cycle.
  - Latch k, we_i[k], addr_i[k] with [2:0] forced to 0, and wdata_i[k].
  - Set pointer = (k+1) mod NUM_REQ.
  - Next state: RD_ADDR if we=0, WR_REQ if we=1.
- While not in IDLE: gnt_o = 0 and req_i is ignored. A requester that drops req_i before its grant is never served and gets no pulse.
- RD_ADDR: ar_valid_o=1, ar_addr_o=latched address, ar_id_o=k. These values stay stable until ar_ready_i. On ar_ready_i, go to RD_DATA.
- RD_DATA:
  - r_ready_o=1.
  - Every beat with r_valid_i: capture r_data_i and OR (r_resp_i[1]) into a sticky error bit.
  - On r_valid_i & r_last_i, go to DONE.
  - Beats without r_last are accepted, and the data of the last beat wins.
- WR_REQ:
  - aw_valid_o and w_valid_o are asserted together; w_strb_o=8'hFF, w_last_o=1, w_data_o=latched data.
  - Each channel's valid drops independently after its handshake, tracked by aw_done/w_done flags.
  - Handshakes may occur in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP: b_ready_o=1. On b_valid_i, set error = b_resp_i[1] and go to DONE.
- DONE, one cycle:
  - rvalid_o[k]=1, rdata_o=captured data (0 for stores), err_o=sticky error.
  - Clear the sticky error and the done flags; return to IDLE.
  - Minimum spacing between grants is therefore 4 cycles for loads (IDLE, RD_ADDR, RD_DATA, DONE) and 4 for stores.
- Throughput: at most one outstanding transaction. Responses therefore need no ID matching, but ar_id_o/aw_id_o still carry k for debug.
- rdata_o and err_o hold their DONE value until the next DONE. rvalid_o is the only qualifier.
- Stray r_valid_i or b_valid_i in the wrong state is not accepted: the corresponding ready is low. This is a protocol violation and is flagged by an assertion.
- Reset mid-transaction: all state is cleared immediately and no rvalid_o pulse is emitted. System reset is expected to reset the interconnect too.
- No timeouts: a slave that never responds stalls the arbiter.

Test Plan:
- Single load: req_i=01, we=0, addr=0x1C00_0013. Expect gnt_o=01 in the same cycle, ar_addr_o=0x1C00_0010, ar_id_o=0. Slave returns 0xDEAD_BEEF_0123_4567 with OKAY. Expect rvalid_o=01, that rdata, err_o=0.
- Single store: req_i=10, we=1, addr=0x1000_0008, wdata=0xA5A5... Slave asserts w_ready two cycles before aw_ready. Expect aw_valid_o to stay up until its handshake, w_strb_o=FF, one W beat, rvalid_o=10 after b_valid.
- Round robin: both requesters hold req continuously for 4 transactions. Expect grant order 0,1,0,1 and no back-to-back grant to the same requester.
- Error: store gets b_resp=2'b10 → err_o=1. The following load gets r_resp=2'b11 on a non-last beat, then OKAY with r_last → err_o=1, and the sticky bit is then cleared.
- Simultaneous AW/W readiness: aw_ready_i=w_ready_i=1 in the same cycle → state goes directly to WR_RESP next cycle.
- Reset asserted during RD_DATA → all outputs 0 asynchronously. After release, a new req from requester 1 is granted, since the pointer resets to 0 and only requester 1 is requesting.
